// File: rtl/tinyriscv_pkg.sv
// Shared bus widths, types and constants for the tinyriscv fetch path.
package tinyriscv_pkg;

  localparam int unsigned InstBusWidth     = 32;
  localparam int unsigned InstAddrBusWidth = 32;

  typedef logic [InstBusWidth-1:0]     InstBus;
  typedef logic [InstAddrBusWidth-1:0] InstAddrBus;

  localparam InstBus     NopInst      = 32'h0000_0013;
  localparam InstAddrBus CpuResetAddr = 32'h0000_0000;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    InstAddrBus addr;
    InstBus     data;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Parameterised synchronous FIFO with flush; push is accepted on a full FIFO
// only when a pop happens in the same cycle.
module if_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AddrW-1:0] rd_ptr;
  logic [AddrW-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AddrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AddrW'(1);
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the PC, issues word fetches, buffers the
// returned words and drops in-flight fetches when ex redirects.
import tinyriscv_pkg::*;

module if_prefetch #(
  parameter int unsigned DEPTH      = 2,
  parameter InstAddrBus  RESET_ADDR = CpuResetAddr
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_jump_flag_i,
  input  InstAddrBus ex_jump_addr_i,
  input  logic       id_ready_i,
  output logic       imem_req_o,
  output InstAddrBus imem_addr_o,
  input  logic       imem_gnt_i,
  input  logic       imem_rvalid_i,
  input  InstBus     imem_rdata_i,
  output logic       inst_valid_o,
  output InstBus     inst_o,
  output InstAddrBus inst_addr_o
);

  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam int unsigned SumW = CntW + 1;

  InstAddrBus   pc;
  logic [CntW-1:0] outstanding;
  logic [CntW-1:0] drop;

  logic         fetch_fire;
  logic         rsp_valid;
  logic         rsp_keep;
  logic         inst_pop;
  logic [SumW-1:0] in_use;

  fetch_entry_t    ifq_wdata;
  fetch_entry_t    ifq_head;
  logic            ifq_full;
  logic            ifq_empty;
  logic [CntW-1:0] ifq_count;

  InstAddrBus      aq_head;
  logic            aq_full;
  logic            aq_empty;
  logic [CntW-1:0] aq_count;

  logic            jump_addr_unused;

  // Every granted fetch must already own a FIFO slot, so in-flight plus buffered is capped.
  assign in_use      = SumW'(outstanding) + SumW'(ifq_count);
  assign imem_req_o  = !ex_jump_flag_i && (in_use < SumW'(DEPTH));
  assign imem_addr_o = pc;
  assign fetch_fire  = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding is ignored; a response in a redirect cycle is stale.
  assign rsp_valid = imem_rvalid_i && (outstanding != '0);
  assign rsp_keep  = rsp_valid && (drop == '0) && !ex_jump_flag_i;

  assign inst_valid_o = !ifq_empty && !ex_jump_flag_i;
  assign inst_o       = inst_valid_o ? ifq_head.data : NopInst;
  assign inst_addr_o  = inst_valid_o ? ifq_head.addr : '0;
  assign inst_pop     = inst_valid_o && id_ready_i;

  assign ifq_wdata        = '{addr: aq_head, data: imem_rdata_i};
  assign jump_addr_unused = ^ex_jump_addr_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= {RESET_ADDR[InstAddrBusWidth-1:2], 2'b00};
      outstanding <= '0;
      drop        <= '0;
    end else if (ex_jump_flag_i) begin
      pc          <= {ex_jump_addr_i[InstAddrBusWidth-1:2], 2'b00};
      outstanding <= outstanding - CntW'(rsp_valid);
      drop        <= outstanding - CntW'(rsp_valid);
    end else begin
      if (fetch_fire) pc <= pc + InstAddrBusWidth'(4);
      outstanding <= outstanding + CntW'(fetch_fire) - CntW'(rsp_valid);
      if (rsp_valid && (drop != '0)) drop <= drop - CntW'(1);
    end
  end

  if_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst),
    .flush (ex_jump_flag_i),
    .push  (rsp_keep),
    .wdata (ifq_wdata),
    .pop   (inst_pop),
    .rdata (ifq_head),
    .full  (ifq_full),
    .empty (ifq_empty),
    .count (ifq_count)
  );

  // Addresses of live (non-dropped) fetches, oldest first.
  if_fifo #(
    .WIDTH (InstAddrBusWidth),
    .DEPTH (DEPTH)
  ) u_addr_queue (
    .clk   (clk),
    .rst_n (rst),
    .flush (ex_jump_flag_i),
    .push  (fetch_fire),
    .wdata (pc),
    .pop   (rsp_keep),
    .rdata (aq_head),
    .full  (aq_full),
    .empty (aq_empty),
    .count (aq_count)
  );

  a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid_i |-> (outstanding != '0));
  a_aq_has_addr: assert property (@(posedge clk) disable iff (!rst)
    rsp_keep |-> !aq_empty);
  a_aq_room: assert property (@(posedge clk) disable iff (!rst)
    fetch_fire |-> !aq_full);
  a_ifq_room: assert property (@(posedge clk) disable iff (!rst)
    (rsp_keep && ifq_full) |-> inst_pop);
  a_inflight_split: assert property (@(posedge clk) disable iff (!rst)
    (SumW'(aq_count) + SumW'(drop)) == SumW'(outstanding));

endmodule

// File: tb/tb_if_prefetch.sv
// Randomised and directed bench for if_prefetch against a queue-based model
// of in-flight fetches and buffered instructions.
module tb_if_prefetch;
  import tinyriscv_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RST_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        id_ready_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(DEPTH), .RESET_ADDR(RST_ADDR)) dut (
    .clk(clk), .rst(rst),
    .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
    .id_ready_i(id_ready_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gnt_pct, rdy_pct, jmp_pct, lat_min, lat_max;

  // Model: buffered instructions, in-flight fetches (with stale flag), pc.
  logic [31:0] m_pc;
  logic [31:0] m_fa[$];
  logic [31:0] m_fd[$];
  logic [31:0] m_la[$];
  bit          m_ls[$];
  // Memory: granted addresses with their response-due cycle.
  logic [31:0] mq_a[$];
  int          mq_d[$];
  // Logs of accepted instruction addresses and granted fetch addresses.
  logic [31:0] acc_q[$];
  logic [31:0] glog[$];

  logic        o_req[16];
  logic        o_valid[16];
  logic [31:0] o_addr[16];
  logic [31:0] o_iaddr[16];
  logic [31:0] o_inst[16];
  logic        last_valid;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idx(input string name, input logic [31:0] q[$], input int idx,
                         input logic [31:0] exp);
    logic [31:0] act;
    act = (idx < q.size()) ? q[idx] : 32'hxxxx_xxxx;
    chk(name, act, exp);
  endtask

  task automatic set_knobs(input int g, input int r, input int j, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; jmp_pct = j; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic drive_inputs();
    imem_rvalid_i  = (mq_a.size() > 0) && (mq_d[0] <= cyc);
    imem_rdata_i   = imem_rvalid_i ? memfn(mq_a[0]) : $urandom;
    imem_gnt_i     = int'($urandom_range(99)) < gnt_pct;
    id_ready_i     = int'($urandom_range(99)) < rdy_pct;
    ex_jump_flag_i = int'($urandom_range(99)) < jmp_pct;
    ex_jump_addr_i = $urandom;
  endtask

  // One cycle: compare outputs at negedge, advance model and memory, drive next inputs.
  task automatic step();
    logic        exp_req, exp_valid, grant;
    bit          s;
    logic [31:0] a, exp_inst, exp_iaddr;
    @(negedge clk);
    exp_req = !ex_jump_flag_i && ((m_la.size() + m_fa.size()) < DEPTH);
    chk("imem_req_o", 32'(imem_req_o), 32'(exp_req));
    if (exp_req) chk("imem_addr_o", imem_addr_o, m_pc);
    exp_valid = (m_fa.size() != 0) && !ex_jump_flag_i;
    exp_inst  = exp_valid ? m_fd[0] : NopInst;
    exp_iaddr = exp_valid ? m_fa[0] : 32'h0;
    chk("inst_valid_o", 32'(inst_valid_o), 32'(exp_valid));
    chk("inst_o", inst_o, exp_inst);
    chk("inst_addr_o", inst_addr_o, exp_iaddr);
    last_valid = inst_valid_o;
    if (cyc < 16) begin
      o_req[cyc] = imem_req_o; o_addr[cyc] = imem_addr_o; o_valid[cyc] = inst_valid_o;
      o_iaddr[cyc] = inst_addr_o; o_inst[cyc] = inst_o;
    end
    grant = imem_req_o && imem_gnt_i;
    s = 1'b1; a = 32'h0;
    if (imem_rvalid_i) begin
      if (m_la.size() > 0) begin a = m_la.pop_front(); s = m_ls.pop_front(); end
      if (mq_a.size() > 0) begin void'(mq_a.pop_front()); void'(mq_d.pop_front()); end
    end
    if (exp_valid && id_ready_i) begin
      acc_q.push_back(m_fa.pop_front());
      void'(m_fd.pop_front());
    end
    if (imem_rvalid_i && !s && !ex_jump_flag_i) begin
      m_fa.push_back(a); m_fd.push_back(memfn(a));
    end
    if (ex_jump_flag_i) begin
      m_fa.delete(); m_fd.delete();
      foreach (m_ls[i]) m_ls[i] = 1'b1;
      m_pc = {ex_jump_addr_i[31:2], 2'b00};
    end else if (grant) begin
      m_la.push_back(m_pc); m_ls.push_back(1'b0); glog.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    if (grant) begin
      mq_a.push_back(imem_addr_o);
      mq_d.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    @(posedge clk); #1;
    cyc++;
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; ex_jump_flag_i = 1'b0; id_ready_i = 1'b0;
    ex_jump_addr_i = 32'h0; imem_rdata_i = 32'h0;
    m_fa.delete(); m_fd.delete(); m_la.delete(); m_ls.delete();
    mq_a.delete(); mq_d.delete(); acc_q.delete(); glog.delete();
    m_pc = RST_ADDR;
    repeat (2) @(posedge clk);
    #1;
    chk("rst inst_valid_o", 32'(inst_valid_o), 32'h0);
    chk("rst inst_o", inst_o, NopInst);
    chk("rst inst_addr_o", inst_addr_o, 32'h0);
    cyc = 0;
    drive_inputs();
    rst = 1'b1;
  endtask

  initial begin
    bit found;
    rst = 1'b0;

    // Streaming from reset with a 1-cycle memory.
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    repeat (12) step();
    chk("A c0 req", 32'(o_req[0]), 32'h1);
    chk("A c0 addr", o_addr[0], 32'h0);
    chk("A c1 valid", 32'(o_valid[1]), 32'h0);
    chk("A c2 valid", 32'(o_valid[2]), 32'h1);
    chk("A c2 inst", o_inst[2], 32'h0010_0093);
    chk("A c2 addr", o_iaddr[2], 32'h0);
    chk_idx("A acc1", acc_q, 1, 32'h4);
    chk_idx("A acc2", acc_q, 2, 32'h8);
    chk_idx("A acc3", acc_q, 3, 32'hC);

    // Decode stalls for 5 cycles, then resumes.
    set_knobs(100, 0, 0, 1, 1);
    do_reset();
    repeat (5) step();
    chk("B stall req", 32'(o_req[4]), 32'h0);
    chk("B stall valid", 32'(o_valid[4]), 32'h1);
    chk("B stall addr", o_iaddr[4], 32'h0);
    chk("B stall inst", o_inst[4], 32'h0010_0093);
    rdy_pct = 100;
    repeat (10) step();
    chk_idx("B acc0", acc_q, 0, 32'h0);
    chk_idx("B acc1", acc_q, 1, 32'h4);
    chk_idx("B acc2", acc_q, 2, 32'h8);

    // Redirect to 0x100 with two fetches in flight (latency 3).
    set_knobs(100, 100, 0, 3, 3);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (m_la.size() == 2);
    end
    chk("C setup", 32'(found), 32'h1);
    ex_jump_flag_i = 1'b1; ex_jump_addr_i = 32'h0000_0100;
    acc_q.delete();
    step();
    chk("C jump valid", 32'(last_valid), 32'h0);
    for (int i = 0; i < 40 && acc_q.size() < 2; i++) step();
    chk_idx("C acc0", acc_q, 0, 32'h100);
    chk_idx("C acc1", acc_q, 1, 32'h104);

    // Redirect to 0x203 in the same cycle as a response.
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = imem_rvalid_i && (cyc >= 3);
    end
    chk("D setup", 32'(found), 32'h1);
    ex_jump_flag_i = 1'b1; ex_jump_addr_i = 32'h0000_0203;
    glog.delete(); acc_q.delete();
    step();
    chk("D jump valid", 32'(last_valid), 32'h0);
    for (int i = 0; i < 40 && acc_q.size() < 1; i++) step();
    chk_idx("D fetch", glog, 0, 32'h200);
    chk_idx("D acc0", acc_q, 0, 32'h200);

    // PC wrap at the top of the address space.
    step();
    ex_jump_flag_i = 1'b1; ex_jump_addr_i = 32'hFFFF_FFF8;
    glog.delete(); acc_q.delete();
    step();
    for (int i = 0; i < 40 && acc_q.size() < 3; i++) step();
    chk_idx("E fetch0", glog, 0, 32'hFFFF_FFF8);
    chk_idx("E fetch1", glog, 1, 32'hFFFF_FFFC);
    chk_idx("E fetch2", glog, 2, 32'h0000_0000);
    chk_idx("E acc2", acc_q, 2, 32'h0000_0000);

    // Randomised traffic under several memory/decode profiles.
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: set_knobs(70, 70, 3, 1, 4);
        1: set_knobs(100, 100, 0, 1, 1);
        2: set_knobs(40, 90, 5, 1, 6);
        3: set_knobs(90, 30, 2, 2, 5);
        default: set_knobs(100, 50, 10, 1, 3);
      endcase
      do_reset();
      repeat (600) step();
    end

    // Asynchronous reset mid-burst with one fetch still outstanding.
    set_knobs(100, 0, 0, 3, 3);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = (m_la.size() == 1) && (m_fa.size() >= 1);
    end
    chk("G setup", 32'(found), 32'h1);
    #2;
    chk("G pre valid", 32'(inst_valid_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("G async valid", 32'(inst_valid_o), 32'h0);
    chk("G async inst", inst_o, NopInst);
    chk("G async addr", inst_addr_o, 32'h0);
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    step();
    chk("G c0 req", 32'(o_req[0]), 32'h1);
    chk("G c0 addr", o_addr[0], RST_ADDR);
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
